// File: rtl/reduce_seq_ctrl_pkg.sv
// Shared definitions for the multi-beat reduction sequencer: op codes, FSM states
// and per-op helper functions.
package reduce_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_e;
   typedef enum logic [1:0] {CLS_AND = 2'd0, CLS_OR = 2'd1, CLS_XOR = 2'd2} op_class_e;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_XNOR);
   endfunction

   function automatic op_class_e op_class(input logic [2:0] op);
      op_class_e cls;
      case (op)
         OP_AND, OP_NAND: cls = CLS_AND;
         OP_OR,  OP_NOR:  cls = CLS_OR;
         default:         cls = CLS_XOR;
      endcase
      return cls;
   endfunction

   // Starting accumulator value that leaves the first folded beat unchanged.
   function automatic logic op_identity(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

   function automatic logic op_invert(input logic [2:0] op);
      return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
   endfunction

endpackage

// File: rtl/reduce_seq_ctrl_if.sv
// Command, input-beat and result handshake bundle for reduce_seq_ctrl.
interface reduce_seq_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
);
   logic              start;
   logic [2:0]        op;
   logic [CNT_W-1:0]  num_beats;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_result;
   logic              out_err;

   modport master (
      output start, op, num_beats, in_valid, in_data, out_ready,
      input  busy, in_ready, out_valid, out_result, out_err
   );

   modport slave (
      input  start, op, num_beats, in_valid, in_data, out_ready,
      output busy, in_ready, out_valid, out_result, out_err
   );
endinterface

// File: rtl/reduce_seq_ctrl_lane.sv
// Combinational single-word bit reduction selected by op class.
module reduce_lane
   import reduce_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_i,
   input  op_class_e         cls_i,
   output logic              bit_o
);

   // Select the word-level reduction for the current op class.
   always_comb begin
      bit_o = 1'b0;
      case (cls_i)
         CLS_AND: bit_o = &data_i;
         CLS_OR:  bit_o = |data_i;
         CLS_XOR: bit_o = ^data_i;
         default: bit_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/reduce_seq_ctrl.sv
// Multi-beat reduction sequencer: folds num_beats input words into one result bit
// and presents it on a valid/ready output.
module reduce_seq_ctrl
   import reduce_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input logic               clk,
   input logic               rst_n,
   reduce_seq_ctrl_if.slave  bus
);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             acc_q, acc_d;
   logic             err_q, err_d;
   logic             res_q, res_d;
   op_class_e        cls_s;
   logic             lane_bit_s;
   logic             fold_s;

   assign cls_s = op_class(op_q);

   reduce_lane #(.DATA_W(DATA_W)) u_lane (
      .data_i (bus.in_data),
      .cls_i  (cls_s),
      .bit_o  (lane_bit_s)
   );

   // Accumulator value after folding the beat currently on the bus.
   always_comb begin
      fold_s = acc_q;
      case (cls_s)
         CLS_AND: fold_s = acc_q & lane_bit_s;
         CLS_OR:  fold_s = acc_q | lane_bit_s;
         CLS_XOR: fold_s = acc_q ^ lane_bit_s;
         default: fold_s = acc_q;
      endcase
   end

   // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      acc_d   = acc_q;
      err_d   = err_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (!op_legal(bus.op) || (bus.num_beats == {CNT_W{1'b0}})) begin
                  err_d   = 1'b1;
                  res_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  op_d    = bus.op;
                  count_d = bus.num_beats;
                  acc_d   = op_identity(bus.op);
                  err_d   = 1'b0;
                  state_d = ACCUM;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d   = fold_s;
               count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
               // Result is latched here so DONE outputs come straight from flops.
               if (count_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  res_d   = fold_s ^ op_invert(op_q);
                  state_d = DONE;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         count_q <= {CNT_W{1'b0}};
         acc_q   <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.in_ready   = (state_q == ACCUM);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = res_q;
   assign bus.out_err    = err_q;

endmodule

// File: tb/tb_reduce_seq_ctrl.sv
// Self-checking bench for reduce_seq_ctrl: directed cases plus randomized commands
// compared against a behavioural reduction model.
module tb_reduce_seq_ctrl;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         tests = 0;
   int         fails = 0;
   logic [7:0] beats [16];

   reduce_seq_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   reduce_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Result straight from the op definition: all-ones, any-one, or odd total parity.
   function automatic logic model(input logic [2:0] op, input int n);
      int   ones;
      bit   all_ones;
      bit   any_one;
      logic r;
      ones = 0; all_ones = 1'b1; any_one = 1'b0;
      if (op > 3'd5 || n == 0) return 1'b0;
      for (int i = 0; i < n; i++) begin
         ones += $countones(beats[i]);
         if (beats[i] != 8'hFF) all_ones = 1'b0;
         if (beats[i] != 8'h00) any_one = 1'b1;
      end
      case (op)
         3'd0, 3'd2: r = all_ones;
         3'd1, 3'd3: r = any_one;
         default:    r = (ones % 2 == 1);
      endcase
      if (op == 3'd2 || op == 3'd3 || op == 3'd5) r = ~r;
      return r;
   endfunction

   task automatic run_cmd(input logic [2:0] op, input int n, input bit gaps,
                          input int hold, input bit poke);
      int   cyc;
      int   i;
      int   guard;
      logic exp_r;
      logic exp_e;
      exp_r = model(op, n);
      exp_e = (op > 3'd5) || (n == 0);
      bus.start = 1'b1; bus.op = op; bus.num_beats = n[3:0];
      tick();
      cyc = 1;
      bus.start = 1'b0; bus.op = 3'($urandom); bus.num_beats = 4'($urandom);
      chk("busy_after_start", 32'(bus.busy), 32'd1);
      if (exp_e) begin
         chk("illegal_no_ready", 32'(bus.in_ready), 32'd0);
      end else begin
         i = 0; guard = 0;
         while (i < n && guard < 200) begin
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = beats[i];
            chk("in_ready_accum", 32'(bus.in_ready), 32'd1);
            chk("no_early_valid", 32'(bus.out_valid), 32'd0);
            tick();
            cyc++; guard++;
            if (bus.in_valid) i++;
         end
         bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
         chk("beat_guard", 32'(guard < 200), 32'd1);
         if (!gaps) chk("latency", 32'(cyc), 32'(n + 1));
      end
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_result", 32'(bus.out_result), 32'(exp_r));
         chk("hold_err", 32'(bus.out_err), 32'(exp_e));
         chk("hold_busy", 32'(bus.busy), 32'd1);
         chk("hold_no_ready", 32'(bus.in_ready), 32'd0);
         if (poke && h == 0) begin
            bus.start = 1'b1; bus.op = 3'd0; bus.num_beats = 4'd1;
         end
         tick();
         bus.start = 1'b0;
      end
      chk("done_valid", 32'(bus.out_valid), 32'd1);
      chk("done_result", 32'(bus.out_result), 32'(exp_r));
      chk("done_err", 32'(bus.out_err), 32'(exp_e));
      bus.out_ready = 1'b1;
      bus.start     = poke;
      bus.op        = 3'd1;
      bus.num_beats = 4'd2;
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      chk("idle_after_hs", 32'(bus.busy), 32'd0);
      chk("valid_dropped", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'd0; bus.num_beats = 4'd0;
      bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.out_result), 32'd0);
      chk("rst_err", 32'(bus.out_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // AND over three beats, then with one cleared bit.
      beats[0] = 8'hFF; beats[1] = 8'hFF; beats[2] = 8'hFF;
      run_cmd(3'd0, 3, 1'b0, 0, 1'b0);
      chk("and_all_ones", 32'(bus.out_result), 32'd1);
      beats[1] = 8'hFE;
      run_cmd(3'd0, 3, 1'b0, 1, 1'b0);

      // XNOR parity cases.
      beats[0] = 8'h01; beats[1] = 8'h03;
      run_cmd(3'd5, 2, 1'b0, 1, 1'b0);
      beats[0] = 8'h01; beats[1] = 8'h02;
      run_cmd(3'd5, 2, 1'b0, 1, 1'b0);
      beats[0] = 8'h03; beats[1] = 8'h03;
      run_cmd(3'd5, 2, 1'b0, 1, 1'b0);

      // Illegal op and zero beat count.
      run_cmd(3'd6, 2, 1'b0, 2, 1'b0);
      run_cmd(3'd7, 5, 1'b0, 1, 1'b1);
      run_cmd(3'd1, 0, 1'b0, 2, 1'b0);

      // OR with input gaps, held output, and starts during DONE / handshake.
      beats[0] = 8'h00; beats[1] = 8'h10;
      run_cmd(3'd1, 2, 1'b1, 5, 1'b1);

      // Reset in the middle of a four-beat AND.
      bus.start = 1'b1; bus.op = 3'd0; bus.num_beats = 4'd4;
      tick();
      bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
      tick(); tick();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_result", 32'(bus.out_result), 32'd0);
      chk("midrst_err", 32'(bus.out_err), 32'd0);
      beats[0] = 8'h00;
      run_cmd(3'd3, 1, 1'b0, 1, 1'b0);

      // Maximum length XOR, immediately followed by another command.
      for (int k = 0; k < 15; k++) beats[k] = 8'h01;
      run_cmd(3'd4, 15, 1'b0, 0, 1'b0);
      beats[0] = 8'h7F; beats[1] = 8'hFF;
      run_cmd(3'd2, 2, 1'b0, 0, 1'b0);

      // Randomized commands against the reference model.
      for (int t = 0; t < 30; t++) begin
         logic [2:0] rop;
         int         rn;
         rop = 3'($urandom_range(0, 7));
         rn  = $urandom_range(0, 15);
         for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
               0:       beats[k] = 8'h00;
               1, 2:    beats[k] = 8'hFF;
               default: beats[k] = 8'($urandom);
            endcase
         end
         run_cmd(rop, rn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
